// File: rtl/spi_responder_pkg.sv
// Shared SPI responder types and constants.
// FSM encoding, byte width and default fill byte.
package spi_responder_pkg;

   localparam int BYTE_W = 8;

   localparam logic [BYTE_W-1:0] FILL_DEFAULT = 8'hFF;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

endpackage

// File: rtl/spi_responder_sync_edge.sv
// N-stage synchroniser with rise/fall strobes.
// Reset level is configurable so idle-high lines do not glitch.
module spi_sync_edge #(
   parameter int   N       = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic [N-1:0] r_sync;
   logic         r_prev;
   logic         w_q;

   assign w_q    = r_sync[N-1];
   assign o_rise = w_q & ~r_prev;
   assign o_fall = ~w_q & r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {N{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[N-2:0], i_d};
         r_prev <= w_q;
      end
   end

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder, oversampled in the system clock domain.
// Byte-wide RX strobe and a one-deep TX holding register.
module spi_responder
   import spi_responder_pkg::*;
#(
   parameter logic [BYTE_W-1:0] FILL_BYTE   = FILL_DEFAULT,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              spi_clk,
   input  logic              spi_cs,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [BYTE_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic              tx_underrun,
   output logic              selected,
   output logic              frame_abort
);

   logic w_rise;
   logic w_fall;
   logic w_cs_rise;
   logic w_cs_fall;
   logic w_mosi;
   logic w_load;
   logic w_take;

   logic [SYNC_STAGES-1:0] r_mosi_sync;

   state_t            r_state;
   logic [2:0]        r_bit_cnt;
   logic [BYTE_W-2:0] r_rx_shift;
   logic [BYTE_W-1:0] r_tx_shift;
   logic [BYTE_W-1:0] r_hold;
   logic              r_tx_ready;
   logic              r_miso;
   logic              r_oe;
   logic [BYTE_W-1:0] r_rx_data;
   logic              r_rx_valid;
   logic              r_underrun;
   logic              r_selected;
   logic              r_abort;

   spi_sync_edge #(
      .N       (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_sclk (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_d     (spi_clk),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   spi_sync_edge #(
      .N       (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_cs (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_d     (spi_cs),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mosi_sync <= '0;
      end else begin
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      end
   end

   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   // Load events: frame start, or a falling edge on a byte boundary.
   assign w_load = (r_state == ST_IDLE) ? w_cs_fall
                 : (~w_cs_rise & w_fall & (r_bit_cnt == 3'd0));

   assign w_take = tx_load & r_tx_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= 3'd0;
         r_rx_shift <= '0;
         r_tx_shift <= FILL_BYTE;
         r_hold     <= '0;
         r_tx_ready <= 1'b1;
         r_miso     <= FILL_BYTE[BYTE_W-1];
         r_oe       <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_underrun <= 1'b0;
         r_selected <= 1'b0;
         r_abort    <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_underrun <= 1'b0;
         r_abort    <= 1'b0;
         r_miso     <= r_tx_shift[BYTE_W-1];

         // Empty register: fill goes out, a same-cycle strobe is still kept.
         if (w_load) begin
            if (!r_tx_ready) begin
               r_tx_shift <= r_hold;
               r_tx_ready <= 1'b1;
            end else begin
               r_tx_shift <= FILL_BYTE;
               r_underrun <= 1'b1;
            end
         end

         if (w_take) begin
            r_hold     <= tx_data;
            r_tx_ready <= 1'b0;
         end

         unique case (r_state)
            ST_IDLE: begin
               r_bit_cnt <= 3'd0;
               r_oe      <= 1'b0;
               if (w_cs_fall) begin
                  r_state    <= ST_ACTIVE;
                  r_oe       <= 1'b1;
                  r_selected <= 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (w_cs_rise) begin
                  r_state    <= ST_IDLE;
                  r_bit_cnt  <= 3'd0;
                  r_oe       <= 1'b0;
                  r_selected <= 1'b0;
                  r_abort    <= (r_bit_cnt != 3'd0);
               end else begin
                  if (w_rise) begin
                     r_rx_shift <= {r_rx_shift[BYTE_W-3:0], w_mosi};
                     r_bit_cnt  <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_rx_data  <= {r_rx_shift, w_mosi};
                        r_rx_valid <= 1'b1;
                     end
                  end
                  if (w_fall && (r_bit_cnt != 3'd0)) begin
                     r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
                  end
               end
            end
         endcase
      end
   end

   assign spi_miso    = r_miso;
   assign spi_miso_oe = r_oe;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign tx_ready    = r_tx_ready;
   assign tx_underrun = r_underrun;
   assign selected    = r_selected;
   assign frame_abort = r_abort;

endmodule
